// File: rtl/cordic_rot_iter.sv
// Iterative rotation-mode CORDIC: Q32.32 angle in, Q32.32 cosine/sine out,
// one micro-rotation per clock. valid/ready handshakes on both sides.
module cordic_rot_iter #(
    parameter int ITER = 32
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic [63:0] angle_i,
    output logic        valid_o,
    input  logic        ready_i,
    output logic [63:0] cos_o,
    output logic [63:0] sin_o,
    output logic        range_err_o
);

    // Handshake: a transfer happens on a rising edge where valid and ready are
    // both high; ready_o is high only in IDLE, valid_o only in DONE.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [4:0]         LAST_IDX = 5'(ITER - 1);
    localparam logic signed [63:0] K_INIT   = 64'sh0000_0000_9B74_EDA8;
    localparam logic signed [63:0] HALF_PI  = 64'sh0000_0001_921F_B544;

    state_t             state_q, state_d;
    logic signed [63:0] x_q, x_d;
    logic signed [63:0] y_q, y_d;
    logic signed [63:0] z_q, z_d;
    logic [4:0]         i_q, i_d;
    logic               range_err_q, range_err_d;
    logic signed [63:0] atan_val;
    logic signed [63:0] x_sh;
    logic signed [63:0] y_sh;
    logic signed [63:0] angle_s;

    assign angle_s = $signed(angle_i);
    assign x_sh    = x_q >>> i_q;
    assign y_sh    = y_q >>> i_q;

    // round(atan(2^-i) * 2^32); from i = 11 on this is exactly 2^(32-i).
    always_comb begin
        atan_val = 64'sd0;
        case (i_q)
            5'd0:  atan_val = 64'sh0000_0000_C90F_DAA2;
            5'd1:  atan_val = 64'sh0000_0000_76B1_9C16;
            5'd2:  atan_val = 64'sh0000_0000_3EB6_EBF2;
            5'd3:  atan_val = 64'sh0000_0000_1FD5_BA9B;
            5'd4:  atan_val = 64'sh0000_0000_0FFA_ADDC;
            5'd5:  atan_val = 64'sh0000_0000_07FF_556F;
            5'd6:  atan_val = 64'sh0000_0000_03FF_EAAB;
            5'd7:  atan_val = 64'sh0000_0000_01FF_FD55;
            5'd8:  atan_val = 64'sh0000_0000_00FF_FFAB;
            5'd9:  atan_val = 64'sh0000_0000_007F_FFF5;
            5'd10: atan_val = 64'sh0000_0000_003F_FFFF;
            5'd11: atan_val = 64'sh0000_0000_0020_0000;
            5'd12: atan_val = 64'sh0000_0000_0010_0000;
            5'd13: atan_val = 64'sh0000_0000_0008_0000;
            5'd14: atan_val = 64'sh0000_0000_0004_0000;
            5'd15: atan_val = 64'sh0000_0000_0002_0000;
            5'd16: atan_val = 64'sh0000_0000_0001_0000;
            5'd17: atan_val = 64'sh0000_0000_0000_8000;
            5'd18: atan_val = 64'sh0000_0000_0000_4000;
            5'd19: atan_val = 64'sh0000_0000_0000_2000;
            5'd20: atan_val = 64'sh0000_0000_0000_1000;
            5'd21: atan_val = 64'sh0000_0000_0000_0800;
            5'd22: atan_val = 64'sh0000_0000_0000_0400;
            5'd23: atan_val = 64'sh0000_0000_0000_0200;
            5'd24: atan_val = 64'sh0000_0000_0000_0100;
            5'd25: atan_val = 64'sh0000_0000_0000_0080;
            5'd26: atan_val = 64'sh0000_0000_0000_0040;
            5'd27: atan_val = 64'sh0000_0000_0000_0020;
            5'd28: atan_val = 64'sh0000_0000_0000_0010;
            5'd29: atan_val = 64'sh0000_0000_0000_0008;
            5'd30: atan_val = 64'sh0000_0000_0000_0004;
            5'd31: atan_val = 64'sh0000_0000_0000_0002;
            default: atan_val = 64'sd0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        i_d         = i_q;
        range_err_d = range_err_q;
        case (state_q)
            ST_IDLE: begin
                if (valid_i) begin
                    state_d     = ST_RUN;
                    x_d         = K_INIT;
                    y_d         = 64'sd0;
                    z_d         = angle_s;
                    i_d         = 5'd0;
                    range_err_d = (angle_s > HALF_PI) || (angle_s < -HALF_PI);
                end
            end
            ST_RUN: begin
                if (!z_q[63]) begin
                    x_d = x_q - y_sh;
                    y_d = y_q + x_sh;
                    z_d = z_q - atan_val;
                end else begin
                    x_d = x_q + y_sh;
                    y_d = y_q - x_sh;
                    z_d = z_q + atan_val;
                end
                // The counter parks on the last index so it never wraps at ITER = 32.
                if (i_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end else begin
                    i_d = i_q + 5'd1;
                end
            end
            ST_DONE: begin
                if (ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            x_q         <= 64'sd0;
            y_q         <= 64'sd0;
            z_q         <= 64'sd0;
            i_q         <= 5'd0;
            range_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            i_q         <= i_d;
            range_err_q <= range_err_d;
        end
    end

    assign ready_o     = (state_q == ST_IDLE);
    assign valid_o     = (state_q == ST_DONE);
    assign cos_o       = x_q;
    assign sin_o       = y_q;
    assign range_err_o = range_err_q;

endmodule

// File: tb/tb_cordic_rot_iter.sv
// Bench for cordic_rot_iter: directed and random angles compared with a
// real-valued cos/sin model, plus latency, backpressure and reset checks.
module tb_cordic_rot_iter;

    localparam int    ITER  = 32;
    localparam real   M_PI  = 3.14159265358979323846;
    localparam real   SCALE = 4294967296.0;
    localparam longint TOL  = 256;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic [63:0] angle_i;
    logic        valid_o;
    logic        ready_i;
    logic [63:0] cos_o;
    logic [63:0] sin_o;
    logic        range_err_o;

    int n_vec = 0;
    int n_err = 0;

    cordic_rot_iter #(.ITER(ITER)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .valid_i     (valid_i),
        .ready_o     (ready_o),
        .angle_i     (angle_i),
        .valid_o     (valid_o),
        .ready_i     (ready_i),
        .cos_o       (cos_o),
        .sin_o       (sin_o),
        .range_err_o (range_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp, input longint tol);
        longint diff;
        n_vec++;
        diff = longint'(obs) - longint'(exp);
        if (diff < 0) diff = -diff;
        if (diff > tol) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Reference: the mathematical cos/sin of the angle, and the |angle| > pi/2 test.
    task automatic model(input logic [63:0] ang, output longint c, output longint s,
                         output logic err);
        longint a_fx;
        longint lim;
        real    a;
        a_fx = ang;
        lim  = longint'($floor(M_PI / 2.0 * SCALE));
        a    = real'(a_fx) / SCALE;
        c    = longint'($cos(a) * SCALE);
        s    = longint'($sin(a) * SCALE);
        err  = (a_fx > lim) || (a_fx < -lim);
    endtask

    task automatic accept(input logic [63:0] ang);
        int guard;
        guard = 0;
        @(negedge clk);
        angle_i = ang;
        valid_i = 1'b1;
        while (!ready_o) begin
            @(negedge clk);
            guard++;
            if (guard > 200) begin
                check("accept_timeout", 64'd0, 64'd1, 0);
                break;
            end
        end
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        angle_i = {$urandom, $urandom};
    endtask

    task automatic wait_valid(input int start, output int lat);
        lat = start;
        forever begin
            @(posedge clk);
            lat++;
            #1;
            if (valid_o) break;
            if (lat > start + 200) begin
                check("valid_timeout", 64'd0, 64'd1, 0);
                break;
            end
        end
    endtask

    task automatic check_result(input logic [63:0] ang);
        longint c, s;
        logic   err;
        model(ang, c, s, err);
        check("valid", 64'(valid_o), 64'd1, 0);
        if (!err) begin
            check("cos", cos_o, c, TOL);
            check("sin", sin_o, s, TOL);
        end
        check("range_err", 64'(range_err_o), 64'(err), 0);
    endtask

    task automatic run_one(input logic [63:0] ang);
        int lat;
        accept(ang);
        wait_valid(0, lat);
        check("latency", 64'(lat), 64'(ITER), 0);
        check_result(ang);
    endtask

    function automatic logic [63:0] rand_in_range();
        logic [63:0] mag;
        logic [63:0] lim;
        lim = 64'h0000_0001_921F_B544;
        mag = {31'd0, 1'($urandom_range(0, 1)), $urandom};
        if (mag > lim) mag = mag - lim;
        return ($urandom_range(0, 1) == 1) ? -mag : mag;
    endfunction

    function automatic logic [63:0] rand_out_range();
        logic [63:0] mag;
        mag = {$urandom_range(2, 32'h7FFF_FFFF), $urandom};
        return ($urandom_range(0, 1) == 1) ? -mag : mag;
    endfunction

    logic [63:0] dir_tab [8] = '{
        64'h0000_0000_0000_0000,
        64'h0000_0000_860A_91C1,
        64'hFFFF_FFFE_6DE0_4ABC,
        64'h0000_0001_921F_B544,
        64'h0000_0001_921F_B545,
        64'hFFFF_FFFE_6DE0_4ABB,
        64'h0000_0002_0000_0000,
        64'hFFFF_FFFF_9B78_5000
    };

    initial begin
        int          lat;
        logic [63:0] ang_a;
        logic [63:0] ang_b;
        longint      c_a, s_a;
        logic        e_a;

        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b1;
        angle_i = 64'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", 64'(ready_o), 64'd1, 0);
        check("rst_valid", 64'(valid_o), 64'd0, 0);
        check("rst_cos", cos_o, 64'd0, 0);
        check("rst_sin", sin_o, 64'd0, 0);
        check("rst_rerr", 64'(range_err_o), 64'd0, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int k = 0; k < 8; k++) run_one(dir_tab[k]);
        for (int k = 0; k < 20; k++) run_one(rand_in_range());
        for (int k = 0; k < 5; k++) run_one(rand_out_range());

        // Backpressure, plus a new offer during RUN that must wait for IDLE.
        ang_a = 64'h0000_0000_860A_91C1;
        ang_b = rand_in_range();
        model(ang_a, c_a, s_a, e_a);
        accept(ang_a);
        repeat (5) @(negedge clk);
        valid_i = 1'b1;
        angle_i = ang_b;
        ready_i = 1'b0;
        wait_valid(5, lat);
        check("bp_latency", 64'(lat), 64'(ITER), 0);
        check_result(ang_a);
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            check("bp_valid", 64'(valid_o), 64'd1, 0);
            check("bp_ready", 64'(ready_o), 64'd0, 0);
            check("bp_cos", cos_o, c_a, TOL);
            check("bp_sin", sin_o, s_a, TOL);
            check("bp_rerr", 64'(range_err_o), 64'(e_a), 0);
        end
        @(negedge clk);
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("rel_ready", 64'(ready_o), 64'd1, 0);
        check("rel_valid", 64'(valid_o), 64'd0, 0);
        @(posedge clk);
        @(negedge clk);
        valid_i = 1'b0;
        check("b_accepted", 64'(ready_o), 64'd0, 0);
        wait_valid(0, lat);
        check("b_latency", 64'(lat), 64'(ITER), 0);
        check_result(ang_b);

        // Reset in the middle of RUN.
        accept(rand_in_range());
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_ready", 64'(ready_o), 64'd1, 0);
        check("mid_rst_valid", 64'(valid_o), 64'd0, 0);
        check("mid_rst_cos", cos_o, 64'd0, 0);
        check("mid_rst_sin", sin_o, 64'd0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("post_rst_valid", 64'(valid_o), 64'd0, 0);
        run_one(64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
